// File: rtl/mem_wb_stage.sv
// MEM stage and MEM/WB pipeline register: data-memory access against an internal word array.
// Optional feature macro: MEM_BYTE_STORE_EN enables `sb` byte-lane stores.
module mem_wb_stage #(
    parameter int ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWrite_Input,
    input  logic        MemtoReg_Input,
    input  logic        MemRead_Input,
    input  logic        MemWrite_Input,
    input  logic        Byte_Store_Input,
    input  logic [4:0]  EX_MEM_RD_Input,
    input  logic [31:0] ALU_Result_Input,
    input  logic [31:0] RT_32_Bit_Input,
    output logic        RegWrite_Output,
    output logic        MemtoReg_Output,
    output logic [4:0]  MEM_WB_RD_Fowarding,
    output logic [4:0]  MEM_WB_RD_Output,
    output logic [31:0] ALU_Result_Output,
    output logic [31:0] Read_Data_Output,
    output logic        Misaligned_Error
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [31:0] mem [DEPTH];

    logic [ADDR_BITS-1:0] word_idx;
    logic [1:0]           byte_lane;
    logic                 byte_store;
    logic                 misaligned;
    logic                 mem_we;
    logic [31:0]          rd_word;
    logic [31:0]          wr_word;

    logic        reg_write_q, reg_write_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // Upper address bits are dropped, so addresses wrap modulo the array size.
    assign word_idx  = ALU_Result_Input[ADDR_BITS+1:2];
    assign byte_lane = ALU_Result_Input[1:0];

`ifdef MEM_BYTE_STORE_EN
    assign byte_store = MemWrite_Input & Byte_Store_Input;
`else
    logic unused_byte_store;
    assign unused_byte_store = Byte_Store_Input;
    assign byte_store        = 1'b0;
`endif

    // NOTE: every variable driven here gets a default first, so no latch can be inferred.
    always_comb begin
        misaligned = (MemRead_Input | MemWrite_Input) & (|byte_lane) & ~byte_store;
        mem_we     = MemWrite_Input & ~misaligned;
        rd_word    = mem[word_idx];
        wr_word    = RT_32_Bit_Input;
        if (byte_store) begin
            wr_word                            = rd_word;
            wr_word[{byte_lane, 3'b000} +: 8]  = RT_32_Bit_Input[7:0];
        end

        reg_write_d  = RegWrite_Input & ~misaligned;
        mem_to_reg_d = MemtoReg_Input;
        rd_d         = EX_MEM_RD_Input;
        alu_d        = ALU_Result_Input;
        rdata_d      = (MemRead_Input && !misaligned) ? rd_word : 32'h0;
        err_d        = err_q | misaligned;
    end

    // NOTE: non-blocking assignments throughout, so a same-edge load sees the pre-write word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the memory array is deliberately not reset; writes are simply held off.
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            rd_q         <= 5'd0;
            alu_q        <= 32'h0;
            rdata_q      <= 32'h0;
            err_q        <= 1'b0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            rd_q         <= rd_d;
            alu_q        <= alu_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            if (mem_we) begin
                mem[word_idx] <= wr_word;
            end
        end
    end

    assign RegWrite_Output     = reg_write_q;
    assign MemtoReg_Output     = mem_to_reg_q;
    assign MEM_WB_RD_Fowarding = rd_q;
    assign MEM_WB_RD_Output    = rd_q;
    assign ALU_Result_Output   = alu_q;
    assign Read_Data_Output    = rdata_q;
    assign Misaligned_Error    = err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage (honours MEM_BYTE_STORE_EN when defined).
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        reg_write, mem_to_reg, mem_read, mem_write, byte_store;
    logic [4:0]  rd_in;
    logic [31:0] alu_in, rt_in;

    logic        RegWrite_Output, MemtoReg_Output, Misaligned_Error;
    logic [4:0]  MEM_WB_RD_Fowarding, MEM_WB_RD_Output;
    logic [31:0] ALU_Result_Output, Read_Data_Output;

    int checks = 0;
    int errors = 0;

    mem_wb_stage #(.ADDR_BITS(8)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .RegWrite_Input      (reg_write),
        .MemtoReg_Input      (mem_to_reg),
        .MemRead_Input       (mem_read),
        .MemWrite_Input      (mem_write),
        .Byte_Store_Input    (byte_store),
        .EX_MEM_RD_Input     (rd_in),
        .ALU_Result_Input    (alu_in),
        .RT_32_Bit_Input     (rt_in),
        .RegWrite_Output     (RegWrite_Output),
        .MemtoReg_Output     (MemtoReg_Output),
        .MEM_WB_RD_Fowarding (MEM_WB_RD_Fowarding),
        .MEM_WB_RD_Output    (MEM_WB_RD_Output),
        .ALU_Result_Output   (ALU_Result_Output),
        .Read_Data_Output    (Read_Data_Output),
        .Misaligned_Error    (Misaligned_Error)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic rw, input logic mtr, input logic mr, input logic mw,
                         input logic bs, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] rt);
        reg_write  = rw;
        mem_to_reg = mtr;
        mem_read   = mr;
        mem_write  = mw;
        byte_store = bs;
        rd_in      = rd;
        alu_in     = alu;
        rt_in      = rt;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        drive(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        #1 rst_n = 1'b0;
        tick();
        tick();
        checks++; if ({RegWrite_Output, MemtoReg_Output, Misaligned_Error} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b expected 000", {RegWrite_Output, MemtoReg_Output, Misaligned_Error}); end
        checks++; if (Read_Data_Output !== 32'h0 || ALU_Result_Output !== 32'h0) begin errors++; $display("FAIL reset_data: got %h/%h expected 0/0", Read_Data_Output, ALU_Result_Output); end
        rst_n = 1'b1;
        drive(0, 0, 0, 1, 0, 5'd0, 32'h80, 32'h01234567);
        tick();
        drive(1, 1, 1, 0, 0, 5'd7, 32'h80, 32'h0);
        tick();
        checks++; if (Read_Data_Output !== 32'h01234567 || MEM_WB_RD_Output !== 5'd7) begin errors++; $display("FAIL pre_reset_load: got %h rd %0d expected 01234567 rd 7", Read_Data_Output, MEM_WB_RD_Output); end
        // Async reset between edges must clear everything before the next edge.
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({RegWrite_Output, MemtoReg_Output, Misaligned_Error} !== 3'b000) begin errors++; $display("FAIL async_reset_ctrl: got %b expected 000", {RegWrite_Output, MemtoReg_Output, Misaligned_Error}); end
        checks++; if (MEM_WB_RD_Output !== 5'd0 || MEM_WB_RD_Fowarding !== 5'd0) begin errors++; $display("FAIL async_reset_rd: got %0d/%0d expected 0/0", MEM_WB_RD_Output, MEM_WB_RD_Fowarding); end
        checks++; if (Read_Data_Output !== 32'h0 || ALU_Result_Output !== 32'h0) begin errors++; $display("FAIL async_reset_data: got %h/%h expected 0/0", Read_Data_Output, ALU_Result_Output); end
        drive(0, 0, 0, 1, 0, 5'd0, 32'h80, 32'hFFFFFFFF);
        tick();
        drive(1, 1, 1, 0, 0, 5'd8, 32'h80, 32'h0);
        rst_n = 1'b1;
        tick();
        checks++; if (Read_Data_Output !== 32'h01234567) begin errors++; $display("FAIL reset_inhibits_write: got %h expected 01234567", Read_Data_Output); end
        checks++; if (MEM_WB_RD_Output !== 5'd8 || RegWrite_Output !== 1'b1) begin errors++; $display("FAIL first_edge_after_reset: got rd %0d rw %b expected rd 8 rw 1", MEM_WB_RD_Output, RegWrite_Output); end
    endtask

    task automatic test_store_load;
        drive(0, 0, 0, 1, 0, 5'd0, 32'h10, 32'hDEADBEEF);
        tick();
        checks++; if (Read_Data_Output !== 32'h0 || RegWrite_Output !== 1'b0) begin errors++; $display("FAIL store_outputs: got %h rw %b expected 0 rw 0", Read_Data_Output, RegWrite_Output); end
        drive(1, 1, 1, 0, 0, 5'd5, 32'h10, 32'h0);
        tick();
        checks++; if (Read_Data_Output !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data: got %h expected deadbeef", Read_Data_Output); end
        checks++; if (MEM_WB_RD_Output !== 5'd5 || MEM_WB_RD_Fowarding !== 5'd5) begin errors++; $display("FAIL load_rd: got %0d/%0d expected 5/5", MEM_WB_RD_Output, MEM_WB_RD_Fowarding); end
        checks++; if ({RegWrite_Output, MemtoReg_Output, Misaligned_Error} !== 3'b110) begin errors++; $display("FAIL load_ctrl: got %b expected 110", {RegWrite_Output, MemtoReg_Output, Misaligned_Error}); end
        checks++; if (ALU_Result_Output !== 32'h10) begin errors++; $display("FAIL load_alu: got %h expected 00000010", ALU_Result_Output); end
    endtask

    task automatic test_read_before_write;
        drive(0, 0, 0, 1, 0, 5'd0, 32'h20, 32'h11111111);
        tick();
        drive(1, 1, 1, 1, 0, 5'd6, 32'h20, 32'h22222222);
        tick();
        checks++; if (Read_Data_Output !== 32'h11111111) begin errors++; $display("FAIL rbw_old: got %h expected 11111111", Read_Data_Output); end
        drive(1, 1, 1, 0, 0, 5'd6, 32'h20, 32'h0);
        tick();
        checks++; if (Read_Data_Output !== 32'h22222222) begin errors++; $display("FAIL rbw_new: got %h expected 22222222", Read_Data_Output); end
    endtask

    task automatic test_wrap_passthrough;
        drive(0, 0, 0, 1, 0, 5'd0, 32'h400, 32'h5A5A5A5A);
        tick();
        drive(1, 1, 1, 0, 0, 5'd2, 32'h000, 32'h0);
        tick();
        checks++; if (Read_Data_Output !== 32'h5A5A5A5A) begin errors++; $display("FAIL addr_wrap: got %h expected 5a5a5a5a", Read_Data_Output); end
        drive(1, 0, 0, 0, 0, 5'd9, 32'h12345678, 32'hCAFEF00D);
        tick();
        checks++; if (ALU_Result_Output !== 32'h12345678) begin errors++; $display("FAIL passthrough_alu: got %h expected 12345678", ALU_Result_Output); end
        checks++; if (Read_Data_Output !== 32'h0 || {RegWrite_Output, MemtoReg_Output} !== 2'b10) begin errors++; $display("FAIL passthrough_ctrl: got %h %b expected 0 10", Read_Data_Output, {RegWrite_Output, MemtoReg_Output}); end
        checks++; if (MEM_WB_RD_Fowarding !== 5'd9 || Misaligned_Error !== 1'b0) begin errors++; $display("FAIL passthrough_rd: got %0d err %b expected 9 err 0", MEM_WB_RD_Fowarding, Misaligned_Error); end
    endtask

    task automatic test_byte_store;
        logic        exp_err;
        logic [31:0] exp_word;
`ifdef MEM_BYTE_STORE_EN
        exp_err  = 1'b0;
        exp_word = 32'h00AB0000;
`else
        exp_err  = 1'b1;
        exp_word = 32'h00000000;
`endif
        drive(0, 0, 0, 1, 0, 5'd0, 32'h40, 32'h0);
        tick();
        drive(0, 0, 0, 1, 1, 5'd0, 32'h42, 32'h123456AB);
        tick();
        checks++; if (Misaligned_Error !== exp_err) begin errors++; $display("FAIL sb_error: got %b expected %b", Misaligned_Error, exp_err); end
        drive(1, 1, 1, 0, 0, 5'd4, 32'h40, 32'h0);
        tick();
        checks++; if (Read_Data_Output !== exp_word) begin errors++; $display("FAIL sb_word: got %h expected %h", Read_Data_Output, exp_word); end
    endtask

    task automatic test_misaligned;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (Misaligned_Error !== 1'b0) begin errors++; $display("FAIL mis_pre: got %b expected 0", Misaligned_Error); end
        drive(1, 1, 1, 0, 0, 5'd3, 32'h13, 32'h0);
        tick();
        checks++; if (Read_Data_Output !== 32'h0 || RegWrite_Output !== 1'b0) begin errors++; $display("FAIL mis_load: got %h rw %b expected 0 rw 0", Read_Data_Output, RegWrite_Output); end
        checks++; if (Misaligned_Error !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b expected 1", Misaligned_Error); end
        checks++; if (MemtoReg_Output !== 1'b1 || MEM_WB_RD_Output !== 5'd3) begin errors++; $display("FAIL mis_passthrough: got mtr %b rd %0d expected mtr 1 rd 3", MemtoReg_Output, MEM_WB_RD_Output); end
        drive(0, 0, 0, 1, 0, 5'd0, 32'h11, 32'h99999999);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 1, 0, 0, 5'd1, 32'h10, 32'h0);
            tick();
        end
        checks++; if (Misaligned_Error !== 1'b1) begin errors++; $display("FAIL mis_sticky: got %b expected 1", Misaligned_Error); end
        checks++; if (Read_Data_Output !== 32'hDEADBEEF) begin errors++; $display("FAIL mis_store_blocked: got %h expected deadbeef", Read_Data_Output); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (Misaligned_Error !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b expected 0", Misaligned_Error); end
        tick();
        rst_n = 1'b1;
        drive(1, 1, 1, 0, 0, 5'd1, 32'h10, 32'h0);
        tick();
        checks++; if (Misaligned_Error !== 1'b0 || Read_Data_Output !== 32'hDEADBEEF) begin errors++; $display("FAIL mis_after_reset: got err %b data %h expected err 0 data deadbeef", Misaligned_Error, Read_Data_Output); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_read_before_write();
        test_wrap_passthrough();
        test_byte_store();
        test_misaligned();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
